// File: rtl/lane_arbiter.sv
// lane_arbiter: sequencer for the single-lane entrance/exit barrier pair.
// Grants one barrier at a time (round-robin on ties, entrance refused while
// the lot is full), closes it on passage or timeout, then holds both barriers
// closed for a guard interval before the next grant.
//
// Handshake note: there is no valid/ready pair here. req_in/req_out are
// levels sampled only in IDLE; enter/exit are one-cycle pulses sampled only
// in the matching OPEN state. All outputs come straight from flops.
module lane_arbiter #(
  parameter int TIMEOUT = 1000,
  parameter int GUARD   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_in,
  input  logic       req_out,
  input  logic       full,
  input  logic       enter,
  input  logic       exit,
  output logic       gate_in,
  output logic       gate_out,
  output logic       deny,
  output logic       timeout,
  output logic       busy,
  output logic [1:0] fsm_state
);

  localparam int MAXV = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
  localparam int TW   = $clog2(MAXV + 1);

  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD - 1);
  localparam logic [TW-1:0] TMAX       = TW'(MAXV);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] OPEN_IN  = 2'd1;
  localparam logic [1:0] OPEN_OUT = 2'd2;
  localparam logic [1:0] CLOSE    = 2'd3;

  // last-granted direction: 0 = entrance, 1 = exit
  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  logic [1:0]    state, state_nx;
  logic [TW-1:0] timer, timer_nx, timer_inc;
  logic          last, last_nx;
  logic          timeout_nx;
  logic          elig_in;

  // Entrance requests are only eligible while the lot has room
  assign elig_in   = req_in & ~full;
  // Saturating increment so the timer can never wrap
  assign timer_inc = (timer == TMAX) ? timer : timer + TW'(1);
  assign fsm_state = state;

  // Next-state, timer, round-robin pointer and timeout-pulse decisions
  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    last_nx    = last;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        if (elig_in && req_out) begin
          // Tie: serve the direction opposite the one granted last
          if (last == DIR_OUT) begin
            state_nx = OPEN_IN;
            last_nx  = DIR_IN;
          end else begin
            state_nx = OPEN_OUT;
            last_nx  = DIR_OUT;
          end
          timer_nx = '0;
        end else if (elig_in) begin
          state_nx = OPEN_IN;
          last_nx  = DIR_IN;
          timer_nx = '0;
        end else if (req_out) begin
          state_nx = OPEN_OUT;
          last_nx  = DIR_OUT;
          timer_nx = '0;
        end
      end
      OPEN_IN: begin
        // A passage on the same edge as expiry wins: no timeout pulse
        if (enter) begin
          state_nx = CLOSE;
          timer_nx = '0;
        end else if (timer == TO_LAST) begin
          state_nx   = CLOSE;
          timer_nx   = '0;
          timeout_nx = 1'b1;
        end else begin
          timer_nx = timer_inc;
        end
      end
      OPEN_OUT: begin
        if (exit) begin
          state_nx = CLOSE;
          timer_nx = '0;
        end else if (timer == TO_LAST) begin
          state_nx   = CLOSE;
          timer_nx   = '0;
          timeout_nx = 1'b1;
        end else begin
          timer_nx = timer_inc;
        end
      end
      default: begin
        // CLOSE: both barriers shut for GUARD cycles, requests not evaluated
        if (timer == GUARD_LAST) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else begin
          timer_nx = timer_inc;
        end
      end
    endcase
  end

  // State register and registered outputs derived from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      timer    <= '0;
      last     <= DIR_OUT;
      gate_in  <= 1'b0;
      gate_out <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      deny     <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      last     <= last_nx;
      gate_in  <= (state_nx == OPEN_IN);
      gate_out <= (state_nx == OPEN_OUT);
      busy     <= (state_nx != IDLE);
      timeout  <= timeout_nx;
      deny     <= req_in & full;
    end
  end

endmodule

// File: tb/tb_lane_arbiter.sv
// tb_lane_arbiter: directed vector table plus hand-written multi-cycle
// sequences for lane_arbiter with TIMEOUT=8, GUARD=2.
module tb_lane_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_in, req_out, full, enter, exit;
  logic       gate_in, gate_out, deny, timeout, busy;
  logic [1:0] fsm_state;

  int total = 0;
  int bad   = 0;
  int mutex_bad = 0;

  lane_arbiter #(.TIMEOUT(8), .GUARD(2)) dut (
    .clk(clk), .reset(reset),
    .req_in(req_in), .req_out(req_out), .full(full),
    .enter(enter), .exit(exit),
    .gate_in(gate_in), .gate_out(gate_out), .deny(deny),
    .timeout(timeout), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Both barriers open together is never allowed
  always @(negedge clk) if (gate_in && gate_out) mutex_bad++;

  // One clock edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_in = 0; req_out = 0; full = 0; enter = 0; exit = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  // in  = {req_in, req_out, full, enter, exit}   applied before the edge
  // exp = {gate_in, gate_out, deny, timeout, busy} sampled after the edge
  typedef struct {
    logic [4:0] in;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[21];

  initial begin
    int n;
    int low;
    int tcount;

    // scenario 1: grant IN, enter after 3 open cycles, 2 guard cycles
    vecs[0]  = '{5'b10000, 5'b10001};
    vecs[1]  = '{5'b00000, 5'b10001};
    vecs[2]  = '{5'b00000, 5'b10001};
    vecs[3]  = '{5'b00010, 5'b00001};
    vecs[4]  = '{5'b00000, 5'b00001};
    vecs[5]  = '{5'b00000, 5'b00000};
    // scenario 5: exit pulse ignored while entrance open
    vecs[6]  = '{5'b10000, 5'b10001};
    vecs[7]  = '{5'b00001, 5'b10001};
    vecs[8]  = '{5'b00010, 5'b00001};
    vecs[9]  = '{5'b00000, 5'b00001};
    vecs[10] = '{5'b00000, 5'b00000};
    // scenario 3: full refuses entrance, exit served, then entrance after full drops
    vecs[11] = '{5'b10100, 5'b00100};
    vecs[12] = '{5'b11100, 5'b01101};
    vecs[13] = '{5'b10100, 5'b01101};
    vecs[14] = '{5'b10101, 5'b00101};
    vecs[15] = '{5'b10000, 5'b00001};
    vecs[16] = '{5'b10000, 5'b00000};
    vecs[17] = '{5'b10000, 5'b10001};
    vecs[18] = '{5'b00010, 5'b00001};
    vecs[19] = '{5'b00000, 5'b00001};
    vecs[20] = '{5'b00000, 5'b00000};

    // reset state
    do_reset();
    chk("rst_outputs", {gate_in, gate_out, deny, timeout, busy}, 5'b00000);
    chk("rst_state", fsm_state, 2'd0);

    for (int i = 0; i < 21; i++) begin
      {req_in, req_out, full, enter, exit} = vecs[i].in;
      step();
      chk($sformatf("vec%0d", i), {gate_in, gate_out, deny, timeout, busy}, vecs[i].exp);
    end
    clear_inputs();

    // scenario 2: both requests held, grants alternate starting with IN
    reset = 1'b0;
    clear_inputs();
    req_in = 1; req_out = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(gate_in || gate_out) && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("s2_grant%0d_dir", g), {gate_in, gate_out}, (g % 2 == 0) ? 2'b10 : 2'b01);
      if (g == 0) chk("s2_first_latency", n, 1);
      else        chk($sformatf("s2_spacing%0d", g), n, 3);
      if (gate_in) enter = 1; else exit = 1;
      step();
      enter = 0; exit = 0;
      chk($sformatf("s2_close%0d", g), {gate_in, gate_out, busy}, 3'b001);
    end
    clear_inputs();

    // scenario 4: exit request with no passage -> timeout after 8 open cycles
    do_reset();
    req_out = 1;
    step();
    chk("s4_grant", {gate_in, gate_out}, 2'b01);
    n = 1;
    while (gate_out && n < 20) begin
      step();
      if (gate_out) n++;
    end
    chk("s4_open_cycles", n, 8);
    chk("s4_timeout_pulse", {timeout, busy}, 2'b11);
    tcount = 0;
    low = 1;
    while (!gate_out && low < 20) begin
      step();
      if (timeout) tcount++;
      if (!gate_out) low++;
    end
    chk("s4_gap_cycles", low, 3);
    chk("s4_single_pulse", tcount, 0);
    chk("s4_regrant_out", {gate_in, gate_out}, 2'b01);
    // second run: exit on the 8th open cycle wins over expiry
    req_out = 0;
    repeat (7) step();
    chk("s4_open_at_8", gate_out, 1'b1);
    exit = 1;
    step();
    exit = 0;
    chk("s4_passage_close", {gate_out, timeout, busy}, 3'b001);
    step();
    chk("s4_no_late_timeout", timeout, 1'b0);
    clear_inputs();

    // scenario 6: asynchronous reset mid OPEN_OUT
    do_reset();
    req_out = 1;
    step();
    chk("s6_grant", gate_out, 1'b1);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("s6_async_drop", {gate_in, gate_out, busy, timeout}, 4'b0000);
    chk("s6_async_state", fsm_state, 2'd0);
    req_in = 1; req_out = 1;
    step();
    reset = 1'b1;
    step();
    chk("s6_first_grant_in", {gate_in, gate_out, timeout}, 3'b100);
    clear_inputs();
    repeat (15) step();

    chk("mutex_never", mutex_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case anything above stalls
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
